alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Arbitrates one combinational 32-bit ALU instance between two requesters: port 0 is the core execute stage and port 1 is the auxiliary unit (debug/address generation). Each port uses a valid/ready request channel and a valid/ready response channel. A round-robin grant selects one request, the block registers its operands, drives the shared ALU for one cycle, and then returns the registered result and zero flag to the winning port. The block sits between the requesters and the ALU; the ALU itself stays outside this block.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU operation code width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request valid per port
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  OP_W  ALU operation code
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- rsp0_valid / rsp1_valid  out  1  response valid
- rsp0_ready / rsp1_ready  in  1  requester takes response
- rsp0_result / rsp1_result  out  DATA_W  registered ALU result
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag
- rsp0_err / rsp1_err  out  1  illegal op flag (see Configuration)
- alu_op  out  OP_W  to shared ALU
- alu_a, alu_b  out  DATA_W  to shared ALU
- alu_result  in  DATA_W  from shared ALU
- alu_zero  in  1  from shared ALU

## Operation
- Legal op codes: 0010 add, 0110 sub, 0000 and, 0001 or, 1100 nor, 1000 xor, 0111 signed set-less-than.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready = grant[N], combinational.
  - grant goes to the single valid port. If both ports are valid, grant goes to the port that was not granted last (rr pointer).
  - On handshake (valid & ready): latch op/a/b into op_q/a_q/b_q, latch owner, update rr pointer, go to EXEC.
- EXEC:
  - ALU inputs are driven from the latched registers.
  - At the clock edge, capture alu_result and alu_zero into res_q/zero_q. Go to RESP.
- RESP:
  - rspN_valid is high only for the owner port. The other rsp_valid is 0.
  - Hold in RESP until rspN_ready=1 for the owner port, then return to IDLE.
- All reqN_ready are 0 in EXEC and RESP; no new request is accepted.
- alu_op/alu_a/alu_b always equal op_q/a_q/b_q, in every state.
- rspN_result, rspN_zero and rspN_err come from shared registers and are only meaningful while rspN_valid=1.
- Requester rule: once reqN_valid is high, it and its payload must stay stable until reqN_ready. The bench asserts this.
- Width: results are DATA_W wide with no extension. SLT returns 32'd1 or 32'd0.

## Timing
- Reset values:
  - state IDLE, all rsp_valid 0.
  - op_q 0000, a_q 0, b_q 0, res_q 0, zero_q 0, err_q 0.
  - rr pointer set so port 0 wins the first contention.
- Latency: request accepted at edge T, EXEC during cycle T+1, rsp_valid high at T+2.
- Throughput: one op per 3 cycles when rsp_ready is held high.
- Response stall: if rsp_ready stays low, the block holds RESP and the response payload indefinitely. The other port is starved for that time.
- Simultaneous request during RESP/EXEC: the request waits. Arbitration is re-evaluated in the first IDLE cycle.
- Reset in EXEC or RESP: the transaction is dropped, no response is issued, and the next cycle is IDLE with reset values.
- Back-to-back contention: grants alternate 0,1,0,1 while both ports stay valid.

## Configuration
- Macro: ALU_ARB_OPCHECK_EN.
- Defined:
  - In IDLE, an accepted op outside the legal list sets err_q=1 and forces op_q=0000 and a_q=b_q=0.
  - The response then returns result 0, zero 1, err 1.
- Undefined:
  - Ops are forwarded to the ALU unchanged.
  - err_q is held at 0, so rspN_err are constant 0.

## Test plan
- Reset, then a single port-0 request op=0010, a=5, b=7 → req0_ready high in the request cycle; rsp0_valid two cycles later with result 12, zero 0; rsp1_valid stays 0.
- Both ports valid from reset: port 0 op=0110, a=9, b=9 and port 1 op=0111, a=0xFFFFFFFF, b=1 → port 0 is served first (result 0, zero 1), then port 1 (result 1, zero 0).
- rsp0_ready held low for 10 cycles while req1 is valid → rsp0_valid and result stay stable and req1_ready stays 0. After rsp0_ready=1, req1 is granted in the next IDLE cycle.
- Assert rst in the EXEC cycle of a port-1 xor request → no rsp1_valid ever appears; all outputs take reset values; the next request completes normally.
- With ALU_ARB_OPCHECK_EN defined, port 0 sends op=1111, a=3, b=4 → rsp0 returns result 0, zero 1, err 1. Without the macro, alu_op=1111 reaches the ALU and rsp0_err=0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two valid/ready requesters.
// Optional illegal-opcode trapping is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_err,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic                zero_q, zero_d, err_q, err_d;
  logic                owner_q, owner_d;
  logic                rr_q, rr_d;
  logic                grant0, grant1;
  logic [OP_W-1:0]     sel_op;
  logic [DATA_W-1:0]   sel_a, sel_b;

`ifdef ALU_ARB_OPCHECK_EN
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_W'(4'b0010)) || (op == OP_W'(4'b0110)) ||
           (op == OP_W'(4'b0000)) || (op == OP_W'(4'b0001)) ||
           (op == OP_W'(4'b1100)) || (op == OP_W'(4'b1000)) ||
           (op == OP_W'(4'b0111));
  endfunction
`endif

  assign sel_op = grant1 ? req1_op : req0_op;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    zero_d     = zero_q;
    err_d      = err_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    grant0     = 1'b0;
    grant1     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      IDLE: begin
        // rr_q holds the last granted port; contention goes to the other one
        grant0 = req0_valid & (~req1_valid | rr_q);
        grant1 = req1_valid & (~req0_valid | ~rr_q);
        if (grant0 | grant1) begin
          owner_d = grant1;
          rr_d    = grant1;
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          err_d   = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
          if (!op_legal(sel_op)) begin
            op_d  = '0;
            a_d   = '0;
            b_d   = '0;
            err_d = 1'b1;
          end
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d  = alu_result;
        zero_d = alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
        if (err_q) begin
          res_d  = '0;
          zero_d = 1'b1;
        end
`endif
        state_d = RESP;
      end
      RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      owner_q <= 1'b0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: provides the external ALU, drives both
// requesters, and checks responses, arbitration order, latency and reset behaviour.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic is_legal(input logic [3:0] op);
    return op inside {4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1000, 4'b0111};
  endfunction

  // Behavioural ALU, also used as the reference for expected results
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b1100: return ~(a | b);
      4'b1000: return a ^ b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  assign alu_result = alu_ref(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == 32'd0);

  typedef struct {
    int          port;
    logic [31:0] res;
    logic        zero;
    logic        err;
    logic [3:0]  aop;
    logic [31:0] aa;
    logic [31:0] ab;
    int          t_acc;
    bit          seen;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  bit   busy = 0, last = 1, after_rst = 0;
  int   rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.port = p; e.t_acc = cyc; e.seen = 0;
    e.aop = op; e.aa = a; e.ab = b; e.err = 1'b0;
    e.res = alu_ref(op, a, b);
`ifdef ALU_ARB_OPCHECK_EN
    if (!is_legal(op)) begin
      e.aop = 4'b0000; e.aa = 32'd0; e.ab = 32'd0; e.err = 1'b1; e.res = 32'd0;
    end
`endif
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  // Requester-side rule: held request stays stable until accepted
  logic        pv0 = 0, pv1 = 0, pr0 = 0, pr1 = 0;
  logic [67:0] pp0 = '0, pp1 = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      busy = 0; last = 1; after_rst = 1;
      pv0 = 0; pv1 = 0;
    end else begin
      if (pv0 && !pr0)
        assert (req0_valid && {req0_op, req0_a, req0_b} == pp0) else $error("req0 unstable");
      if (pv1 && !pr1)
        assert (req1_valid && {req1_op, req1_a, req1_b} == pp1) else $error("req1 unstable");
      pv0 = req0_valid; pr0 = req0_ready; pp0 = {req0_op, req0_a, req0_b};
      pv1 = req1_valid; pr1 = req1_ready; pp1 = {req1_op, req1_a, req1_b};

      if (after_rst) begin
        chk("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_result", rsp0_result, 32'd0);
        chk("rst_zero_err", {30'd0, rsp0_zero, rsp0_err}, 32'd0);
        after_rst = 0;
      end

      if (busy) begin
        chk("ready_while_busy", {30'd0, req1_ready, req0_ready}, 32'd0);
      end else if (req0_valid || req1_valid) begin
        chk("grant_count", 32'(req0_ready) + 32'(req1_ready), 32'd1);
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          int w;
          w = (req1_valid && req1_ready) ? 1 : 0;
          if (req0_valid && req1_valid) chk("rr_winner", 32'(w), 32'(!last));
          if (w == 0) sb.push_back(mk_exp(0, req0_op, req0_a, req0_b));
          else        sb.push_back(mk_exp(1, req1_op, req1_a, req1_b));
          busy = 1; last = w[0];
        end
      end else begin
        chk("idle_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      end

      if (sb.size() > 0 && cyc == sb[0].t_acc + 1) begin
        chk("exec_alu_op", {28'd0, alu_op}, {28'd0, sb[0].aop});
        chk("exec_alu_a", alu_a, sb[0].aa);
        chk("exec_alu_b", alu_b, sb[0].ab);
      end

      if (rsp0_valid || rsp1_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end else begin
          int p;
          p = rsp1_valid ? 1 : 0;
          chk("rsp_single", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
          chk("rsp_port", 32'(p), 32'(sb[0].port));
          if (!sb[0].seen) begin
            chk("rsp_latency", 32'(cyc - sb[0].t_acc), 32'd2);
            sb[0].seen = 1;
          end
          chk("rsp_result", p ? rsp1_result : rsp0_result, sb[0].res);
          chk("rsp_zero", {31'd0, p ? rsp1_zero : rsp0_zero}, {31'd0, sb[0].zero});
          chk("rsp_err", {31'd0, p ? rsp1_err : rsp0_err}, {31'd0, sb[0].err});
          if (p ? rsp1_ready : rsp0_ready) begin
            void'(sb.pop_front());
            busy = 0;
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].t_acc + 2) begin
        chk("rsp_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
        busy = 0;
      end
    end
  end

  // Response-ready driver: 0 = both high, 1 = random, 2 = port 0 stalled
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin rsp0_ready = 1'($urandom_range(0, 1)); rsp1_ready = 1'($urandom_range(0, 1)); end
        2: begin rsp0_ready = 1'b0; rsp1_ready = 1'b1; end
        default: begin rsp0_ready = 1'b1; rsp1_ready = 1'b1; end
      endcase
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    bit got;
    n = 0; got = 0;
    if (p == 0) begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    while (!got && n < 300) begin
      @(negedge clk);
      got = (p == 0) ? req0_ready : req1_ready;
      n++;
    end
    if (!got) chk("req_timeout", 32'(p), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  function automatic logic [3:0] rand_op();
    logic [3:0] ops [7];
    ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b1000, 4'b0111};
    if ($urandom_range(0, 7) == 0) return 4'($urandom);
    return ops[$urandom_range(0, 6)];
  endfunction

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      idle($urandom_range(0, 3));
      send(p, rand_op(), a, b);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    rst = 1'b0;
    idle(1);

    send(0, 4'b0010, 32'd5, 32'd7);
    idle(4);

    rst = 1'b1; idle(2); rst = 1'b0;
    fork
      send(0, 4'b0110, 32'd9, 32'd9);
      send(1, 4'b0111, 32'hFFFF_FFFF, 32'd1);
    join
    idle(4);

    rdy_mode = 2;
    idle(1);
    send(0, 4'b0001, 32'h0F0F_0000, 32'h0000_00F0);
    fork
      begin idle(12); rdy_mode = 0; end
      send(1, 4'b1100, 32'h1234_5678, 32'h0);
    join
    idle(4);

    send(1, 4'b1000, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
    rst = 1'b1; idle(1); rst = 1'b0;
    idle(2);
    send(1, 4'b1000, 32'hFFFF_0000, 32'h00FF_FF00);
    idle(4);

    send(0, 4'b1111, 32'd3, 32'd4);
    idle(4);

    rdy_mode = 1;
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    rdy_mode = 0;
    idle(10);
    chk("drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
